// File: rtl/yousei_io_pkg.sv
// Shared definitions for the IN/OUT handshake logic.
// Provides the handshake FSM state type, the IN/OUT opcodes, the write-back
// mux select for the I/O path, and a button polarity helper.
package yousei_io_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_PRESS = 3'd2,
    DEBOUNCE   = 3'd3,
    CAPTURE    = 3'd4
  } io_state_e;

  localparam logic [5:0] OP_IN      = 6'b001000;
  localparam logic [5:0] OP_OUT     = 6'b001001;
  localparam logic [1:0] MEM2REG_IO = 2'b01;

  // Map a synchronized button level to "pressed" (1) regardless of wiring.
  function automatic logic btn_pressed(input logic sync_level, input logic active_low);
    return active_low ? ~sync_level : sync_level;
  endfunction

endpackage

// File: rtl/io_handshake_controller_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset, clears both stages to 0
//   i_d     - asynchronous input bus
//   o_q     - synchronized output (two cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Synchronizer stages: r_meta may go metastable, r_sync is the clean copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= {WIDTH{1'b0}};
      r_sync <= {WIDTH{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/io_handshake_controller.sv
// IN/OUT instruction sequencer.
// IN (Halt high): stalls the PC and gates the register write until the user
// releases and then presses the debounced confirm button; the synchronized
// switch value is then captured and written once. OUT: latches OutData into
// the display register with a one-cycle strobe.
// Ports:
//   Clock, Reset_n        - system clock, async active-low reset
//   Halt, OpIO, RegWrite  - decoded control from the control unit
//   Switches, ButtonRaw   - raw asynchronous board inputs
//   OutData               - register-file read value for OUT
//   Stall                 - combinational PC freeze
//   WriteEnable           - RegWrite gated by Stall
//   InData, InStrobe      - captured switch value and capture pulse
//   Display, OutStrobe    - last OUT value and its update pulse
//   Waiting               - status LED while waiting for the user
module io_handshake_controller
  import yousei_io_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Halt,
  input  logic              OpIO,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] Switches,
  input  logic              ButtonRaw,
  input  logic [DATA_W-1:0] OutData,
  output logic              Stall,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] InData,
  output logic              InStrobe,
  output logic [DATA_W-1:0] Display,
  output logic              OutStrobe,
  output logic              Waiting
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              w_btn_sync;
  logic              w_btn;
  logic [DATA_W-1:0] w_sw_sync;

  io_state_e         r_state;
  io_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_in_data;
  logic [DATA_W-1:0] r_display;
  logic              r_out_strobe;
  logic              w_stall;
  logic              w_out_fire;
  logic              w_capture_load;

  sync_2ff #(.WIDTH(1)) u_sync_btn (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_d     (ButtonRaw),
    .o_q     (w_btn_sync)
  );

  sync_2ff #(.WIDTH(DATA_W)) u_sync_sw (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_d     (Switches),
    .o_q     (w_sw_sync)
  );

  assign w_btn = btn_pressed(w_btn_sync, BTN_ACTIVE_LOW);

  // Next-state and debounce counter; ARM demands a release first so a press
  // held over from a previous IN cannot confirm the new one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (Halt) w_state_nxt = ARM;
        else      w_state_nxt = IDLE;
      end
      ARM: begin
        if (!w_btn) w_state_nxt = WAIT_PRESS;
        else        w_state_nxt = ARM;
      end
      WAIT_PRESS: begin
        if (w_btn) begin
          w_state_nxt = DEBOUNCE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = WAIT_PRESS;
        end
      end
      DEBOUNCE: begin
        if (!w_btn) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stall covers the IDLE cycle where Halt first appears so the PC never
  // advances past the IN; it drops in CAPTURE so the write-back happens.
  assign w_stall = ((r_state == IDLE) && Halt) ||
                   (r_state == ARM) || (r_state == WAIT_PRESS) || (r_state == DEBOUNCE);
  assign w_out_fire     = (r_state == IDLE) && OpIO && !RegWrite && !Halt;
  assign w_capture_load = (r_state == DEBOUNCE) && (w_state_nxt == CAPTURE);

  // State, counter and data registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_in_data    <= {DATA_W{1'b0}};
      r_display    <= {DATA_W{1'b0}};
      r_out_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_strobe <= w_out_fire;
      if (w_capture_load) r_in_data <= w_sw_sync;
      if (w_out_fire)     r_display <= OutData;
    end
  end

  assign Stall       = w_stall;
  assign WriteEnable = RegWrite && !w_stall;
  assign InData      = r_in_data;
  assign InStrobe    = (r_state == CAPTURE);
  assign Display     = r_display;
  assign OutStrobe   = r_out_strobe;
  assign Waiting     = (r_state == ARM) || (r_state == WAIT_PRESS) || (r_state == DEBOUNCE);

endmodule

// File: tb/tb_io_handshake_controller.sv
// Scoreboard bench for io_handshake_controller (DEBOUNCE_CYCLES=4).
// The reference model tracks an IN as "pending / capture cycle" with a
// release flag and a count of consecutive pressed cycles since the release.
module tb_io_handshake_controller;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          halt, opio, regwrite, btn_raw;
  logic [DW-1:0] sw, out_data;
  logic          stall, we, in_strobe, out_strobe, waiting;
  logic [DW-1:0] in_data, display;

  always #5 clk = ~clk;

  io_handshake_controller #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .Halt(halt), .OpIO(opio), .RegWrite(regwrite),
    .Switches(sw), .ButtonRaw(btn_raw), .OutData(out_data),
    .Stall(stall), .WriteEnable(we), .InData(in_data), .InStrobe(in_strobe),
    .Display(display), .OutStrobe(out_strobe), .Waiting(waiting)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_phase;   // 0 no IN pending, 1 waiting for user, 2 capture cycle
  bit            m_rel;     // a released button has been seen during this IN
  int            m_run;     // pressed cycles since the release
  logic [DW-1:0] m_in_data, m_disp;
  bit            m_out_strobe;
  logic          m_b1, m_b2;
  logic [DW-1:0] m_s1, m_s2;

  typedef struct {
    logic          stall, we, waiting, in_strobe, out_strobe;
    logic [DW-1:0] in_data, display;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rel = 1'b0; m_run = 0;
    m_in_data = '0; m_disp = '0; m_out_strobe = 1'b0;
    m_b1 = 1'b0; m_b2 = 1'b0; m_s1 = '0; m_s2 = '0;
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_step();
    bit pressed;
    bit fire;
    pressed = !m_b2;
    fire = (m_phase == 0) && opio && !regwrite && !halt;
    m_out_strobe = fire;
    if (fire) begin
      m_disp = out_data;
      out_q.push_back(out_data);
    end
    case (m_phase)
      0: if (halt) begin m_phase = 1; m_rel = 1'b0; m_run = 0; end
      1: begin
        if (!pressed) begin
          m_rel = 1'b1; m_run = 0;
        end else if (m_rel) begin
          m_run++;
          if (m_run == N + 1) begin
            m_phase = 2;
            m_in_data = m_s2;
            in_q.push_back(m_s2);
          end
        end
      end
      default: m_phase = 0;
    endcase
    m_b2 = m_b1; m_b1 = btn_raw;
    m_s2 = m_s1; m_s1 = sw;
  endtask

  task automatic push_expect();
    exp_t e;
    e.stall      = (m_phase == 1) ? 1'b1 : (m_phase == 2) ? 1'b0 : halt;
    e.we         = regwrite && !e.stall;
    e.waiting    = (m_phase == 1);
    e.in_strobe  = (m_phase == 2);
    e.out_strobe = m_out_strobe;
    e.in_data    = m_in_data;
    e.display    = m_disp;
    exp_q.push_back(e);
  endtask

  // One clock cycle: step model on the edge, then apply the new inputs.
  task automatic tick(input logic rn, input logic h, input logic op, input logic rw,
                      input logic br, input logic [DW-1:0] s, input logic [DW-1:0] od);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    rst_n = rn; halt = h; opio = op; regwrite = rw; btn_raw = br; sw = s; out_data = od;
    if (!rn) model_reset();
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, sw, out_data);
  endtask

  // Hold an IN with the given raw button level until the model's capture cycle.
  task automatic in_until_capture(input logic br, input logic [DW-1:0] s);
    int i;
    for (i = 0; i < 100 && m_phase != 2; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, br, s, out_data);
    if (m_phase != 2) begin
      checks++; errors++;
      $display("FAIL capture_timeout actual=%0d required=2", m_phase);
    end
  endtask

  // Monitor: compares every cycle and pops the capture/display scoreboards on strobes.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", {31'b0, stall}, {31'b0, e.stall});
      chk("write_enable", {31'b0, we}, {31'b0, e.we});
      chk("waiting", {31'b0, waiting}, {31'b0, e.waiting});
      chk("in_strobe", {31'b0, in_strobe}, {31'b0, e.in_strobe});
      chk("out_strobe", {31'b0, out_strobe}, {31'b0, e.out_strobe});
      chk("in_data", in_data, e.in_data);
      chk("display", display, e.display);
    end
    if (in_strobe === 1'b1) begin
      if (in_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_capture actual=%h required=none", in_data);
      end else chk("capture_value", in_data, in_q.pop_front());
    end
    if (out_strobe === 1'b1) begin
      if (out_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out actual=%h required=none", display);
      end else chk("out_value", display, out_q.pop_front());
    end
  end

  initial begin
    logic [5:0] bounce;
    logic       b;
    rst_n = 1'b0; halt = 1'b0; opio = 1'b0; regwrite = 1'b0;
    btn_raw = 1'b1; sw = '0; out_data = '0;
    model_reset();

    // Reset with Halt low
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    idle(4);

    // Plain IN: button pressed from the first cycle
    in_until_capture(1'b0, 32'h0000_002A);
    idle(4);

    // Bouncy press: low 2, high 1, low 3, high 1, then held low
    bounce = 6'b011000;
    for (int i = 0; i < 7; i++) begin
      b = (i == 2 || i == 6) ? 1'b1 : 1'b0;
      tick(1'b1, 1'b1, 1'b1, 1'b1, b, 32'h0000_00C3, out_data);
    end
    in_until_capture(1'b0, 32'h0000_00C3);
    idle(3);

    // Button held through the end of one IN into the next
    in_until_capture(1'b0, 32'h1111_0001);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2222_0002, out_data);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2222_0002, out_data);
    in_until_capture(1'b0, 32'h2222_0002);
    idle(3);

    // OUT
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, sw, 32'h0000_1234);
    idle(4);

    // Reset in DEBOUNCE with Halt held; IN restarts from ARM afterwards
    for (int i = 0; i < 50 && !(m_phase == 1 && m_rel && m_run >= 2); i++)
      tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, out_data);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, out_data);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, out_data);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, out_data);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0BAD_F00D, out_data);
    in_until_capture(1'b0, 32'h0BAD_F00D);
    idle(3);

    // Randomized traffic
    b = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic rn, h, op, rw;
      int   r;
      rn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 6) == 0) b = ~b;
      if (m_phase == 0) begin
        r = $urandom_range(0, 9);
        if (r < 2)      begin h = 1'b1; op = 1'b1; rw = 1'b1; end
        else if (r < 5) begin h = 1'b0; op = 1'b1; rw = 1'b0; end
        else            begin h = 1'b0; op = 1'b0; rw = 1'($urandom_range(0, 1)); end
      end else begin
        h = ($urandom_range(0, 9) != 0); op = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      end
      tick(rn, h, op, rw, b, $urandom, $urandom);
    end
    idle(4);

    @(negedge clk);
    #1;
    chk("captures_left", 32'(in_q.size()), 32'd0);
    chk("outs_left", 32'(out_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
